// File: rtl/full_multiplication.sv
// Multi-cycle modular arithmetic unit over a fixed odd modulus p.
// Word-serial Montgomery multiply (op 00), modular add/sub (01/10) and copy (11).
package full_multiplication_pkg;

  // (-a)^-1 mod 2^64 by Newton iteration (a odd); each step doubles the correct low bits.
  function automatic logic [63:0] neg_inv64(input logic [63:0] a);
    logic [63:0] x;
    x = a;
    for (int k = 0; k < 5; k++) begin
      x = x * (64'd2 - a * x);
    end
    return -x;
  endfunction

endpackage

module full_multiplication #(
  parameter int unsigned  word_size = 32,
  parameter int unsigned  N         = 1024,
  parameter logic [N-1:0] p         = 1024'h0ece55ed_3a91c7f2_5b6d0e48_9f12a7c3_d4e8b0f6_21c9573a_8e04f6d1_b7a3295c_4f61e0d8_c2957ab3_06d8e14f_93b7c25a_e1f04d86_7a2c9b35_58e3f10c_cd496a27_31b8f5e2_a06c4d79_f27e81b3_4c9d06ea_8b15f3c7_e6203a94_1d7fb85c_95a2e04b_7cf8316d_02b5e9a4_e8c1475f_6a3d92b0_b49e0c71_2f6a85d3_c7e1b028_41e36453,
  parameter logic [N-1:0] p_inv     = N'(full_multiplication_pkg::neg_inv64(64'(p)))
) (
  input  logic         clk,
  input  logic         rst,
  output logic         done,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] C,
  input  logic [1:0]   op
);

  localparam int unsigned W  = word_size;
  localparam int unsigned S  = N / W;
  localparam int unsigned TW = N + W + 2;
  localparam int unsigned PW = N + W;
  localparam int unsigned CW = (S > 1) ? $clog2(S) : 1;

  localparam logic [W-1:0] P_PRIME = p_inv[W-1:0];

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_CPY = 2'b11;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    MUL_ADD = 3'd1,
    REDUCE  = 3'd2,
    FINAL   = 3'd3,
    ADDSUB  = 3'd4,
    FIX     = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_r, b_r, a_nxt, b_nxt, c_nxt;
  logic [1:0]    op_r, op_nxt;
  logic [TW-1:0] t, t_nxt;
  logic [CW-1:0] i, i_nxt;
  logic          done_nxt;

  logic [W-1:0]  b_word, m;
  logic [N-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [PW-1:0] prod;
  logic [TW-1:0] sum, t_sub;
  logic [N-1:0]  t_red;

  // Shared N x w multiplier: A*b_i while accumulating, m*p while reducing.
  always_comb begin
    b_word = W'(b_r >> (32'(i) * W));
    m      = W'(t[W-1:0] * P_PRIME);
    mul_a  = a_r;
    mul_b  = b_word;
    if (state == REDUCE) begin
      mul_a = p;
      mul_b = m;
    end
    prod  = PW'(mul_a) * PW'(mul_b);
    sum   = t + TW'(prod);
    t_sub = t - TW'(p);
    t_red = (t >= TW'(p)) ? t_sub[N-1:0] : t[N-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic; copy passes through FIX so C and done rise together.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (op == OP_MUL)      state_nxt = MUL_ADD;
        else if (op == OP_CPY) state_nxt = FIX;
        else                   state_nxt = ADDSUB;
      end
      MUL_ADD: state_nxt = REDUCE;
      REDUCE:  state_nxt = (i == CW'(S - 1)) ? FINAL : MUL_ADD;
      FINAL:   state_nxt = DONE;
      ADDSUB:  state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  // Datapath and output next values; every register holds unless its state updates it.
  always_comb begin
    a_nxt    = a_r;
    b_nxt    = b_r;
    op_nxt   = op_r;
    t_nxt    = t;
    i_nxt    = i;
    c_nxt    = C;
    done_nxt = done;
    case (state)
      LOAD: begin
        a_nxt  = A;
        b_nxt  = B;
        op_nxt = op;
      end
      MUL_ADD: t_nxt = sum;
      REDUCE: begin
        t_nxt = sum >> W;
        i_nxt = i + CW'(1);
      end
      FINAL: begin
        c_nxt    = t_red;
        done_nxt = 1'b1;
      end
      ADDSUB: begin
        if (op_r == OP_SUB)
          t_nxt = TW'(a_r) - TW'(b_r) + ((a_r < b_r) ? TW'(p) : '0);
        else
          t_nxt = TW'(a_r) + TW'(b_r);
      end
      FIX: begin
        case (op_r)
          OP_ADD:  c_nxt = t_red;
          OP_SUB:  c_nxt = t[N-1:0];
          default: c_nxt = a_r;
        endcase
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      op_r <= '0;
      t    <= '0;
      i    <= '0;
      C    <= '0;
      done <= 1'b0;
    end else begin
      a_r  <= a_nxt;
      b_r  <= b_nxt;
      op_r <= op_nxt;
      t    <= t_nxt;
      i    <= i_nxt;
      C    <= c_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_full_multiplication.sv
// Directed scoreboard bench for full_multiplication at default parameters.
module tb_full_multiplication;

  localparam int unsigned N = 1024;
  localparam int unsigned W = 32;
  localparam int unsigned S = N / W;

  localparam logic [N-1:0] P  = 1024'h0ece55ed_3a91c7f2_5b6d0e48_9f12a7c3_d4e8b0f6_21c9573a_8e04f6d1_b7a3295c_4f61e0d8_c2957ab3_06d8e14f_93b7c25a_e1f04d86_7a2c9b35_58e3f10c_cd496a27_31b8f5e2_a06c4d79_f27e81b3_4c9d06ea_8b15f3c7_e6203a94_1d7fb85c_95a2e04b_7cf8316d_02b5e9a4_e8c1475f_6a3d92b0_b49e0c71_2f6a85d3_c7e1b028_41e36453;
  localparam logic [N-1:0] XA = 1024'h0184c5d2_9e3b7a41_c65f20d8_13a8e94b_7d02f6c5_e4b18a37_52c9d06e_a8f3147b_3e96b2d0_f17c85a4_0b4ed369_c8a257f1_6d9e03b8_27f4c1a6_b05a89e3_94c3672d_e2187f5c_5fa03b96_8c6d41e7_19b7f20a_d3e54c81_a62f9b17_4e80d5c3_f9c1263a_21d7a8e5_c5f0397b_7b2e14d6_e0a6c859_36f98b02_8d5c17e4_b9a04f6c_ae1856f7;

  logic         clk;
  logic         rst;
  logic         done;
  logic [N-1:0] A, B, C;
  logic [1:0]   op;

  int passed = 0;
  int total  = 0;
  logic [N-1:0] exp_q[$];

  full_multiplication dut (
    .clk  (clk),
    .rst  (rst),
    .done (done),
    .A    (A),
    .B    (B),
    .C    (C),
    .op   (op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Radix-2 Montgomery reference: a*b*2^-N mod p.
  function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N+1:0] t;
    t = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (a[k]) t = t + (N+2)'(b);
      if (t[0]) t = t + (N+2)'(P);
      t = t >> 1;
    end
    if (t >= (N+2)'(P)) t = t - (N+2)'(P);
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] add_ref(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = (N+1)'(a) + (N+1)'(b);
    if (s >= (N+1)'(P)) s = s - (N+1)'(P);
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] sub_ref(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    if (a >= b) s = (N+1)'(a) - (N+1)'(b);
    else        s = (N+1)'(a) + (N+1)'(P) - (N+1)'(b);
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] pow2_mod(input int e);
    logic [N:0] r;
    r = (N+1)'(1);
    for (int k = 0; k < e; k++) begin
      r = r << 1;
      if (r >= (N+1)'(P)) r = r - (N+1)'(P);
    end
    return r[N-1:0];
  endfunction

  // Random operand strictly below p (top word kept under p's top word).
  function automatic logic [N-1:0] rnd();
    logic [N-1:0] v;
    for (int k = 0; k < int'(S); k++) v[k*32 +: 32] = $urandom;
    v[N-1 -: 32] = $urandom % 32'h0ece55ed;
    return v;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h..%h exp=%h..%h", tag, got[N-1 -: 48], got[47:0], exp[N-1 -: 48], exp[47:0]);
  endtask

  // Reset, launch one operation, watch it for its full latency, then score C.
  task automatic run(input string tag, input logic [1:0] o, input logic [N-1:0] a,
                     input logic [N-1:0] b, input logic [N-1:0] exp_c);
    int lat;
    logic early, leak;
    logic [N-1:0] want;
    lat = (o == 2'b00) ? int'(2 * S + 2) : ((o == 2'b11) ? 2 : 3);
    exp_q.push_back(exp_c);
    @(negedge clk);
    rst = 1'b1; op = o; A = a; B = b;
    #2;
    check({tag, "/rst_c"}, C, '0);
    check({tag, "/rst_done"}, N'(done), '0);
    @(negedge clk);
    rst = 1'b0;
    early = 1'b0;
    leak  = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k < lat) begin
        if (done !== 1'b0) early = 1'b1;
        if (C !== '0) leak = 1'b1;
      end
    end
    check({tag, "/early_done"}, N'(early), '0);
    check({tag, "/c_leak"}, N'(leak), '0);
    check({tag, "/done"}, N'(done), N'(1));
    want = exp_q.pop_front();
    check({tag, "/c"}, C, want);
  endtask

  initial begin
    logic [N-1:0] exp_aa, r1, r2, x, y;
    rst = 1'b1; op = 2'b00; A = '0; B = '0;
    #10;

    // Main multiply, then hold with inputs wiggling and no reset.
    exp_aa = mont_ref(XA, XA);
    run("mul_aa", 2'b00, XA, XA, exp_aa);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      A = rnd(); B = rnd(); op = 2'(k);
      @(posedge clk);
      #1;
      check("hold/c", C, exp_aa);
      check("hold/done", N'(done), N'(1));
    end

    // Zero operand, then Montgomery identity with B = R mod p.
    x = rnd();
    run("mul_zero", 2'b00, '0, x, '0);
    r1 = pow2_mod(int'(N));
    run("mul_id", 2'b00, XA, r1, XA);
    r2 = pow2_mod(int'(2 * N));
    y = rnd();
    run("mul_r2", 2'b00, y, r2, mont_ref(y, r2));
    x = rnd(); y = rnd();
    run("mul_rnd", 2'b00, x, y, mont_ref(x, y));

    // Modular add/sub boundaries and random cases.
    run("add_wrap", 2'b01, P - N'(1), N'(1), '0);
    run("add_small", 2'b01, N'(1), N'(2), N'(3));
    x = rnd(); y = rnd();
    run("add_rnd", 2'b01, x, y, add_ref(x, y));
    run("sub_wrap", 2'b10, '0, N'(1), P - N'(1));
    run("sub_small", 2'b10, N'(5), N'(3), N'(2));
    x = rnd(); y = rnd();
    run("sub_rnd", 2'b10, x, y, sub_ref(x, y));

    // Abort a multiply mid-flight, then copy.
    @(negedge clk);
    rst = 1'b1; op = 2'b00; A = XA; B = XA;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort/busy_done", N'(done), '0);
    rst = 1'b1;
    #1;
    check("abort/c", C, '0);
    check("abort/done", N'(done), '0);
    run("copy", 2'b11, N'(7), '0, N'(7));

    check("sb/empty", N'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
